// File: rtl/accel_poll_sequencer.sv
// accel_poll_sequencer: ID check, config writes and periodic XYZ polling over i2c_controller; define SEQ_TIMEOUT_EN for the per-transaction watchdog
module accel_poll_sequencer #(
  parameter int SYS_CLK_SPEED = 50000000,
  parameter int SAMPLE_RATE_HZ = 100,
  parameter logic [6:0] ACCEL_ADDR = 7'h1D,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  output logic [6:0]  DEV_ADDR,
  output logic [7:0]  REG_ADDR,
  output logic        R_W,
  output logic [7:0]  WRITE_DATA,
  output logic        start_i2c_comms,
  input  logic [7:0]  READ_DATA,
  input  logic        i2c_comms_finished,
  input  logic        ready,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        overrun,
  output logic        fault,
  output logic [1:0]  fault_code
);
  localparam int P = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
  localparam int TW = $clog2(P);
  localparam logic [TW-1:0] P_LAST = TW'(P - 1);
  if (P < 2 || TIMEOUT_CYCLES < 1) $error("accel_poll_sequencer: bad parameters");
  typedef enum logic [2:0] {CHK_ID, INIT_WR, WAIT_TICK, READ_AXIS, PUBLISH, FAULT} state_t;
  state_t state;
  logic waiting, pending, tick;
  logic [2:0] idx, nidx;
  logic [TW-1:0] tick_cnt;
  logic [39:0] shadow;
`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
`endif
  assign DEV_ADDR = ACCEL_ADDR;
  assign tick = init_done && tick_cnt == P_LAST;
  assign nidx = idx + 3'd1;
  // sequencer: transaction issue/wait, sample-rate tick, shadow capture and atomic publish
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CHK_ID;
      waiting <= 1'b0;
      pending <= 1'b0;
      idx <= '0;
      tick_cnt <= '0;
      shadow <= '0;
      start_i2c_comms <= 1'b0;
      REG_ADDR <= '0;
      R_W <= 1'b1;
      WRITE_DATA <= '0;
      accel_x <= '0;
      accel_y <= '0;
      accel_z <= '0;
      sample_valid <= 1'b0;
      init_done <= 1'b0;
      overrun <= 1'b0;
      fault <= 1'b0;
      fault_code <= 2'b00;
`ifdef SEQ_TIMEOUT_EN
      wd <= '0;
`endif
    end else begin
      start_i2c_comms <= 1'b0;
      sample_valid <= 1'b0;
      if (init_done) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && (state == READ_AXIS || state == PUBLISH)) begin
        overrun <= 1'b1;
        pending <= 1'b1;
      end
`ifdef SEQ_TIMEOUT_EN
      if (waiting) wd <= wd + 1'b1;
`endif
      case (state)
        WAIT_TICK: if (tick) begin
          state <= READ_AXIS;
          waiting <= 1'b0;
          idx <= '0;
          REG_ADDR <= 8'h32;
          R_W <= 1'b1;
        end
        PUBLISH: begin
          state <= (pending || tick) ? READ_AXIS : WAIT_TICK;
          pending <= 1'b0;
          waiting <= 1'b0;
          idx <= '0;
          REG_ADDR <= 8'h32;
          R_W <= 1'b1;
        end
        FAULT: if (restart) begin
          state <= CHK_ID;
          waiting <= 1'b0;
          pending <= 1'b0;
          idx <= '0;
          fault <= 1'b0;
          fault_code <= 2'b00;
          overrun <= 1'b0;
          REG_ADDR <= 8'h00;
          R_W <= 1'b1;
          WRITE_DATA <= 8'h00;
        end
        default: if (!waiting) begin
          if (ready) begin
            start_i2c_comms <= 1'b1;
            waiting <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            wd <= '0;
`endif
          end
        end else if (i2c_comms_finished) begin
          waiting <= 1'b0;
          if (state == CHK_ID) begin
            if (READ_DATA == 8'hE5) begin
              state <= INIT_WR;
              idx <= '0;
              REG_ADDR <= 8'h2C;
              WRITE_DATA <= 8'h0A;
              R_W <= 1'b0;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
              fault_code <= 2'b01;
            end
          end else if (state == INIT_WR) begin
            if (idx == 3'd2) begin
              state <= WAIT_TICK;
              init_done <= 1'b1;
              tick_cnt <= '0;
              idx <= '0;
            end else begin
              idx <= nidx;
              REG_ADDR <= nidx == 3'd1 ? 8'h31 : 8'h2D;
              WRITE_DATA <= 8'h08;
            end
          end else begin
            shadow <= {READ_DATA, shadow[39:8]};
            if (idx == 3'd5) begin
              state <= PUBLISH;
              idx <= '0;
              accel_x <= shadow[15:0];
              accel_y <= shadow[31:16];
              accel_z <= {READ_DATA, shadow[39:32]};
              sample_valid <= 1'b1;
            end else begin
              idx <= nidx;
              REG_ADDR <= 8'h32 + {5'b0, nidx};
            end
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
          state <= FAULT;
          waiting <= 1'b0;
          fault <= 1'b1;
          fault_code <= 2'b10;
          init_done <= 1'b0;
        end
`endif
      endcase
    end
endmodule

// File: tb/tb_accel_poll_sequencer.sv
// tb_accel_poll_sequencer: controller model plus transaction/sample scoreboards for accel_poll_sequencer
module tb_accel_poll_sequencer;
  localparam int P = 400;
  localparam int LAT = 20;
  localparam int TO = 1000;
  logic clk = 1'b0, rst = 1'b1, restart = 1'b0;
  logic [6:0] DEV_ADDR;
  logic [7:0] REG_ADDR, WRITE_DATA, READ_DATA;
  logic R_W, start_i2c_comms, i2c_comms_finished, ready;
  logic [15:0] accel_x, accel_y, accel_z;
  logic sample_valid, init_done, overrun, fault;
  logic [1:0] fault_code;
  accel_poll_sequencer #(.SYS_CLK_SPEED(4000), .SAMPLE_RATE_HZ(10), .ACCEL_ADDR(7'h1D), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .restart(restart), .DEV_ADDR(DEV_ADDR), .REG_ADDR(REG_ADDR), .R_W(R_W),
    .WRITE_DATA(WRITE_DATA), .start_i2c_comms(start_i2c_comms), .READ_DATA(READ_DATA),
    .i2c_comms_finished(i2c_comms_finished), .ready(ready), .accel_x(accel_x), .accel_y(accel_y),
    .accel_z(accel_z), .sample_valid(sample_valid), .init_done(init_done), .overrun(overrun),
    .fault(fault), .fault_code(fault_code));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [7:0] regs [256];
  int lat = LAT;
  bit hang = 1'b0, busy = 1'b0, prev_start = 1'b0, prev_fault = 1'b0;
  int cnt, ncyc = 0, fin37 = -100, nsamp = 0, nstart = 0, last_start = 0;
  logic [7:0] cur_addr, cur_data;
  logic cur_rw;
  logic [16:0] tq [$];
  logic [47:0] sq [$];
  int ax_start [$];
  int gap [$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_init();
    tq.push_back({1'b1, 8'h00, 8'h00});
    tq.push_back({1'b0, 8'h2C, 8'h0A});
    tq.push_back({1'b0, 8'h31, 8'h08});
    tq.push_back({1'b0, 8'h2D, 8'h08});
  endtask
  task automatic push_sample(input logic [47:0] b);
    for (int i = 0; i < 6; i++) begin
      regs[8'h32 + i] = b[8*i +: 8];
      tq.push_back({1'b1, 8'(8'h32 + i), 8'h00});
    end
    sq.push_back({b[15:0], b[31:16], b[47:32]});
  endtask
  task automatic wait_sample(input int bound);
    int n0 = nsamp;
    int k = 0;
    while (nsamp == n0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("sample_arrived", 64'(nsamp != n0), 1);
  endtask
  // behavioural i2c controller and output monitors, all on the falling edge
  initial begin
    ready = 1'b1;
    i2c_comms_finished = 1'b0;
    READ_DATA = 8'h00;
    forever begin
      @(negedge clk);
      ncyc++;
      if (sample_valid) begin
        nsamp++;
        chk("sample_q_nonempty", 64'(sq.size() != 0), 1);
        if (sq.size() != 0) chk("accel_xyz", {accel_x, accel_y, accel_z}, sq.pop_front());
        chk("publish_latency", 64'(ncyc - fin37), 1);
      end
      if (prev_start) chk("start_width", start_i2c_comms, 0);
      prev_start = start_i2c_comms;
`ifdef SEQ_TIMEOUT_EN
      if (fault && !prev_fault && hang) chk("timeout_latency", 64'(ncyc - last_start), TO);
`endif
      prev_fault = fault;
      i2c_comms_finished = 1'b0;
      if (rst) begin
        busy = 1'b0;
        ready = 1'b1;
      end else if (busy) begin
        cnt--;
        if (cnt == 0 && !hang) begin
          busy = 1'b0;
          ready = 1'b1;
          i2c_comms_finished = 1'b1;
          if (cur_rw) begin
            READ_DATA = regs[cur_addr];
            if (cur_addr == 8'h37) fin37 = ncyc;
          end else regs[cur_addr] = cur_data;
        end
      end else if (start_i2c_comms) begin
        busy = 1'b1;
        ready = 1'b0;
        cnt = lat;
        nstart++;
        last_start = ncyc;
        cur_addr = REG_ADDR;
        cur_rw = R_W;
        cur_data = WRITE_DATA;
        chk("dev_addr", DEV_ADDR, 7'h1D);
        chk("txn_q_nonempty", 64'(tq.size() != 0), 1);
        if (tq.size() != 0) chk("txn", {R_W, REG_ADDR, R_W ? 8'h00 : WRITE_DATA}, tq.pop_front());
        if (R_W && REG_ADDR == 8'h32) begin
          ax_start.push_back(ncyc);
          gap.push_back(ncyc - fin37);
        end
      end
    end
  end
  // directed sequence
  initial begin
    int k, n;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_start", start_i2c_comms, 0);
    chk("rst_reg_addr", REG_ADDR, 8'h00);
    chk("rst_r_w", R_W, 1);
    chk("rst_write_data", WRITE_DATA, 8'h00);
    chk("rst_accel", {accel_x, accel_y, accel_z}, 48'h0);
    chk("rst_flags", {sample_valid, init_done, overrun, fault, fault_code}, 6'b0);
    chk("rst_dev_addr", DEV_ADDR, 7'h1D);
    regs[0] = 8'h00;
    tq.push_back({1'b1, 8'h00, 8'h00});
    rst = 1'b0;
    k = 0;
    while (!fault && k < 300) begin @(negedge clk); k++; end
    chk("badid_fault", fault, 1);
    chk("badid_code", fault_code, 2'b01);
    chk("badid_init_done", init_done, 0);
    n = nstart;
    repeat (100) @(negedge clk);
    chk("fault_no_starts", 64'(nstart), 64'(n));
    regs[0] = 8'hE5;
    push_init();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    k = 0;
    while (!init_done && k < 500) begin @(negedge clk); k++; end
    chk("init_done", init_done, 1);
    chk("init_txns_consumed", 64'(tq.size()), 0);
    chk("restart_clears_fault", {fault, fault_code}, 3'b0);
    push_sample(48'h8001_ABCD_1234);
    wait_sample(1000);
    push_sample(48'h807F_FFFF_0000);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_sample(1000);
    chk("restart_ignored", {fault, init_done}, 2'b01);
    chk("period_1", 64'(ax_start[1] - ax_start[0]), P);
    chk("no_overrun", overrun, 0);
    push_sample(48'h0102_0304_0506);
    wait_sample(1000);
    chk("period_2", 64'(ax_start[2] - ax_start[1]), P);
    lat = P + 10;
    push_sample(48'h1111_2222_3333);
    wait_sample(4000);
    chk("overrun_set", overrun, 1);
    push_sample(48'h4444_5555_6666);
    wait_sample(4000);
    chk("pending_gap_slow", 64'(gap[4]), 3);
    lat = LAT;
    push_sample(48'h7777_8888_9999);
    wait_sample(1000);
    chk("pending_gap_fast", 64'(gap[5]), 3);
    push_sample(48'hAAAA_BBBB_CCCC);
    wait_sample(1000);
    push_sample(48'hDDDD_EEEE_FFFF);
    wait_sample(1000);
    push_sample(48'h0F0F_F0F0_5A5A);
    wait_sample(1000);
    chk("single_pending_period", 64'(ax_start[8] - ax_start[7]), P);
    tq.push_back({1'b1, 8'h32, 8'h00});
    tq.push_back({1'b1, 8'h33, 8'h00});
    k = 0;
    while (tq.size() != 0 && k < 1000) begin @(negedge clk); k++; end
    chk("mid_read_reached", 64'(tq.size()), 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_start", start_i2c_comms, 0);
    chk("arst_cmd", {REG_ADDR, R_W, WRITE_DATA}, {8'h00, 1'b1, 8'h00});
    chk("arst_accel", {accel_x, accel_y, accel_z}, 48'h0);
    chk("arst_flags", {sample_valid, init_done, overrun, fault, fault_code}, 6'b0);
    push_init();
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (!init_done && k < 500) begin @(negedge clk); k++; end
    chk("reinit_done", init_done, 1);
    chk("reinit_txns_consumed", 64'(tq.size()), 0);
`ifdef SEQ_TIMEOUT_EN
    hang = 1'b1;
    tq.push_back({1'b1, 8'h32, 8'h00});
    k = 0;
    while (!fault && k < P + TO + 200) begin @(negedge clk); k++; end
    chk("timeout_fault", {fault, fault_code}, 3'b110);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/accel_poll_sequencer.md
# accel_poll_sequencer

Sequencer that owns the command side of `i2c_controller` and drives the accelerometer without software. After reset it checks the device ID, writes a fixed configuration table, then reads the six axis data registers at a programmable sample rate. It publishes each X/Y/Z triple atomically to the 7-segment display path. It sits between `i2c_controller` and the display formatting logic, and is the only master of the controller's command inputs.

## Interface
- `SYS_CLK_SPEED`, 50000000, system clock frequency in Hz.
- `SAMPLE_RATE_HZ`, 100, axis poll rate; tick period `P = SYS_CLK_SPEED/SAMPLE_RATE_HZ` cycles.
- `ACCEL_ADDR`, 7'h1D, 7-bit I2C device address driven on `DEV_ADDR`.
- `TIMEOUT_CYCLES`, 200000, per-transaction watchdog limit. Used only when `SEQ_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `restart` in 1: one-cycle pulse. Leaves FAULT and re-enters CHK_ID.
- `DEV_ADDR` out 7: to controller; constant `ACCEL_ADDR`.
- `REG_ADDR` out 8: register address of the current transaction.
- `R_W` out 1: 1 = read, 0 = write.
- `WRITE_DATA` out 8: write payload.
- `start_i2c_comms` out 1: one-cycle start pulse.
- `READ_DATA` in 8: read result; valid when `i2c_comms_finished` is high.
- `i2c_comms_finished` in 1: one-cycle done pulse from the controller.
- `ready` in 1: controller idle and able to accept a start.
- `accel_x`, `accel_y`, `accel_z` out 16: signed samples, little-endian assembled as {DATAn1, DATAn0}.
- `sample_valid` out 1: one-cycle pulse when new X/Y/Z values are published.
- `init_done` out 1: high once configuration is complete.
- `overrun` out 1: sticky; a tick arrived while a sample read was still in progress.
- `fault` out 1: high while in FAULT.
- `fault_code` out 2: 01 = bad DEVID, 10 = timeout, 00 = none.

## Operation
States: CHK_ID, INIT_WR, WAIT_TICK, READ_AXIS, PUBLISH, FAULT. Each transaction inside a state uses two sub-phases, ISSUE and WAIT.

- **ISSUE**
  - Hold `REG_ADDR`, `R_W` and `WRITE_DATA` stable.
  - On the first cycle with `ready=1`, assert `start_i2c_comms` for exactly one cycle, then go to WAIT.
  - Command outputs stay stable until `i2c_comms_finished` is seen.
- **WAIT**
  - On `i2c_comms_finished`, capture `READ_DATA` for reads, then advance.
- **CHK_ID**
  - Read register 0x00.
  - Value 0xE5 -> INIT_WR.
  - Any other value -> FAULT with code 01.
- **INIT_WR**
  - Write table entries in order: (0x2C←0x0A), (0x31←0x08), (0x2D←0x08).
  - After the third finish, set `init_done`, clear the tick counter, go to WAIT_TICK.
- **WAIT_TICK**
  - Tick counter counts 0..P-1 and wraps; it runs continuously while `init_done=1`.
  - At the wrap, go to READ_AXIS.
- **READ_AXIS**
  - Six single-byte reads of 0x32..0x37 into shadow registers.
  - Register index 0..5 wraps to 0 after entry 5.
- **PUBLISH**
  - In one cycle, copy the shadow registers to `accel_x`/`accel_y`/`accel_z`, pulse `sample_valid`, return to WAIT_TICK.
  - Outputs never show a mix of old and new bytes.
- **Tick during READ_AXIS or PUBLISH**
  - Set `overrun`. Latch one pending tick; further ticks are not counted.
  - If a tick is pending, PUBLISH goes directly to READ_AXIS.
- **FAULT**
  - `fault=1`, `start_i2c_comms=0`, `init_done=0`.
  - `restart` clears `fault`, `fault_code` and `overrun`, then enters CHK_ID.
  - `restart` outside FAULT is ignored.

## Timing
- **Reset values**
  - State CHK_ID (ISSUE); all counters 0.
  - `start_i2c_comms=0`, `REG_ADDR=0`, `R_W=1`, `WRITE_DATA=0`.
  - `accel_*=0`, `sample_valid=0`, `init_done=0`, `overrun=0`, `fault=0`, `fault_code=00`.
  - `DEV_ADDR=ACCEL_ADDR`.
- **Start latency:** `start_i2c_comms` rises on the clock after `ready` is sampled high in ISSUE. If `ready` is already high on ISSUE entry, it rises one cycle after entry.
- **Publish latency:** `sample_valid` fires 1 cycle after the `i2c_comms_finished` of register 0x37. The `accel_*` outputs update on the same edge.
- **Simultaneous `i2c_comms_finished` and tick:** process the finish normally; record the tick as pending.
- **Spurious `i2c_comms_finished`** outside WAIT is ignored.
- **Reset mid-transaction:** everything returns to the reset values immediately and asynchronously. The sequence restarts at CHK_ID after `rst` deasserts.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A watchdog counter clears on each start pulse and counts every cycle in WAIT.
  - Reaching `TIMEOUT_CYCLES` -> FAULT with code 10.
- `SEQ_TIMEOUT_EN` undefined:
  - No watchdog logic; WAIT lasts indefinitely.
  - `fault_code` can only be 00 or 01.

## Test plan
Benches use a behavioural controller model: `ready` high when idle, `i2c_comms_finished` 20 cycles after start, with an 8-bit register file.

- **DEVID 0xE5:** exactly 1 read of 0x00, then 3 writes 0x2C/0x31/0x2D with data 0x0A/0x08/0x08 in order, then `init_done=1`. Each start pulse is exactly 1 cycle.
- **DEVID 0x00:** `fault=1`, `fault_code=01`, no further starts. A `restart` pulse with the model returning 0xE5 -> normal init.
- **Axis read:** model regs 0x32..0x37 = 34 12 CD AB 01 80 -> `accel_x=16'h1234`, `accel_y=16'hABCD`, `accel_z=16'h8001`, `sample_valid` 1 cycle after the 6th finish, and the next sample begins P cycles after the previous tick.
- **Slow model (finish after P+10 cycles):** `overrun=1`; the next READ_AXIS follows PUBLISH with no WAIT_TICK gap, and only one pending tick is honoured.
- **`SEQ_TIMEOUT_EN`, model never finishes:** FAULT with code 10 exactly `TIMEOUT_CYCLES` after the start pulse.
- **`rst` asserted mid-READ_AXIS:** all outputs return to their reset values asynchronously; after deassertion the first transaction is a read of 0x00.
